// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle sequencing FSM for the CPU datapath: fetch/decode/execute/memory/writeback
// over stallable instruction and data memory handshakes, with a retired-instruction counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | imem request outstanding; IR latched when imem_ready
// DECODE | classify opcode; J completes here, HALT/illegal stop here
// EXEC   | ALU operation; BEQ completes here
// MEM    | dmem request outstanding; SW completes on dmem_ready
// WB     | register file write and PC+4
// HALT   | absorbing until RESET
module multi_cycle_ctrl #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_HALT  = 6'b111111,
   parameter int         CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [5:0]       opcode,
   input  logic             zf,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_we,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             rf_we,
   output logic             alu_src_imm,
   output logic             wb_from_mem,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             halted,
   output logic             illegal,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t           r_state;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;

   logic w_is_rtype;
   logic w_is_addi;
   logic w_is_lw;
   logic w_is_sw;
   logic w_is_beq;
   logic w_is_j;
   logic w_is_halt;
   logic w_legal;

   logic       w_imem_req;
   logic       w_ir_we;
   logic       w_dmem_req;
   logic       w_dmem_we;
   logic       w_rf_we;
   logic       w_alu_src_imm;
   logic       w_wb_from_mem;
   logic       w_pc_we;
   logic [1:0] w_pc_sel;
   logic       w_halted;

   assign w_is_rtype = (opcode == OP_RTYPE);
   assign w_is_addi  = (opcode == OP_ADDI);
   assign w_is_lw    = (opcode == OP_LW);
   assign w_is_sw    = (opcode == OP_SW);
   assign w_is_beq   = (opcode == OP_BEQ);
   assign w_is_j     = (opcode == OP_J);
   assign w_is_halt  = (opcode == OP_HALT);
   assign w_legal    = w_is_rtype | w_is_addi | w_is_lw | w_is_sw |
                       w_is_beq | w_is_j | w_is_halt;

   always_comb begin
      w_imem_req    = 1'b0;
      w_ir_we       = 1'b0;
      w_dmem_req    = 1'b0;
      w_dmem_we     = 1'b0;
      w_rf_we       = 1'b0;
      w_alu_src_imm = 1'b0;
      w_wb_from_mem = 1'b0;
      w_pc_we       = 1'b0;
      w_pc_sel      = 2'b00;
      w_halted      = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_imem_req = 1'b1;
            w_ir_we    = imem_ready;
         end
         S_DECODE: begin
            if (w_is_j) begin
               w_pc_we  = 1'b1;
               w_pc_sel = 2'b10;
            end
         end
         S_EXEC: begin
            w_alu_src_imm = w_is_addi | w_is_lw | w_is_sw;
            if (w_is_beq) begin
               w_pc_we  = 1'b1;
               w_pc_sel = {1'b0, zf};
            end
         end
         S_MEM: begin
            w_alu_src_imm = 1'b1;
            w_dmem_req    = 1'b1;
            w_dmem_we     = w_is_sw;
            // a store retires in the cycle its access completes; PC holds while stalled
            w_pc_we       = dmem_ready & w_is_sw;
         end
         S_WB: begin
            w_rf_we       = 1'b1;
            w_wb_from_mem = w_is_lw;
            w_alu_src_imm = ~w_is_rtype;
            w_pc_we       = 1'b1;
         end
         S_HALT: begin
            w_halted = 1'b1;
         end
         default: begin
            w_halted = 1'b0;
         end
      endcase
   end

   // every instruction retires exactly on its single pc_we cycle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_retired <= '0;
      end else begin
         if (w_pc_we) begin
            r_retired <= r_retired + CNT_W'(1);
         end
         case (r_state)
            S_FETCH: begin
               if (imem_ready) begin
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_is_halt) begin
                  r_state <= S_HALT;
               end else if (!w_legal) begin
                  r_illegal <= 1'b1;
                  r_state   <= S_HALT;
               end else if (w_is_j) begin
                  r_state <= S_FETCH;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_is_rtype || w_is_addi) begin
                  r_state <= S_WB;
               end else if (w_is_lw || w_is_sw) begin
                  r_state <= S_MEM;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  r_state <= w_is_lw ? S_WB : S_FETCH;
               end
            end
            S_WB: begin
               r_state <= S_FETCH;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   assign imem_req    = w_imem_req;
   assign ir_we       = w_ir_we;
   assign dmem_req    = w_dmem_req;
   assign dmem_we     = w_dmem_we;
   assign rf_we       = w_rf_we;
   assign alu_src_imm = w_alu_src_imm;
   assign wb_from_mem = w_wb_from_mem;
   assign pc_we       = w_pc_we;
   assign pc_sel      = w_pc_sel;
   assign halted      = w_halted;
   assign illegal     = r_illegal;
   assign state       = r_state;
   assign retired     = r_retired;

endmodule
